// File: rtl/cpu_decode_issue.sv
// cpu_decode_issue: holds one instruction, issues its micro-steps to execute, and stalls stack
// readers on a pending-stack-op scoreboard. Define CPU_DECODE_SKID_EN for a one-entry input skid.
module cpu_decode_issue #(
  parameter int IW       = 48,
  parameter int PCW      = 32,
  parameter int SPW      = 11,
  parameter int PEND_MAX = 7,
  parameter int PW       = $clog2(PEND_MAX + 1)
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           in_valid_1a,
  output logic           in_ready_1a,
  input  logic [IW-1:0]  instruction_1a,
  input  logic [PCW-1:0] pc_1a,
  input  logic [2:0]     steps_1a,
  input  logic [1:0]     pops_1a,
  input  logic [2:0]     pushes_1a,
  input  logic [1:0]     topn_src_1a,
  input  logic           kill_4a,
  input  logic           st_retire_5a,
  input  logic [SPW-1:0] st_saved_sp_3a,
  output logic           out_valid_2a,
  input  logic           out_ready_2a,
  output logic [IW-1:0]  instruction_2a,
  output logic [PCW-1:0] pc_2a,
  output logic [7:0]     opcode_2a,
  output logic [2:0]     step_2a,
  output logic           last_2a,
  output logic           js_mode_2a,
  output logic [SPW-1:0] top_n_offset_2a,
  output logic [PW-1:0]  pending_2a,
  output logic           stall_2a,
  output logic           err_underflow
);

  typedef struct packed {
    logic [IW-1:0]  instr;
    logic [PCW-1:0] pc;
    logic [2:0]     steps;
    logic [1:0]     pops;
    logic [2:0]     pushes;
    logic [1:0]     topn;
  } op_t;

  typedef enum logic {EMPTY, HOLD} state_t;

  localparam logic [1:0] TOPN_NONE   = 2'd0;
  localparam logic [1:0] TOPN_CONST  = 2'd1;
  localparam logic [1:0] TOPN_IMM    = 2'd2;
  localparam logic [1:0] TOPN_IMMREG = 2'd3;

  state_t         state_q;
  op_t            op_q;
  logic [2:0]     step_q;
  logic [PW-1:0]  pend_q;
  logic           err_q;

  op_t            in_op;
  op_t            load_op;
  logic           hold, stack_eff, hazard, fire, last_step, last_fire, hold_free;
  logic           accept, load, sb_inc;
  logic [SPW-1:0] imm;

  assign in_op = '{instr: instruction_1a, pc: pc_1a, steps: steps_1a, pops: pops_1a,
                   pushes: pushes_1a, topn: topn_src_1a};

  assign hold      = (state_q == HOLD);
  assign stack_eff = (op_q.pops != 2'd0) || (op_q.pushes != 3'd0);
  // Only step 0 can be blocked: later steps of an issued instruction never wait on the stack.
  assign hazard    = hold && (step_q == 3'd0) &&
                     (((pend_q != '0) && ((op_q.pops != 2'd0) || (op_q.topn == TOPN_IMMREG))) ||
                      ((pend_q == PW'(PEND_MAX)) && stack_eff));
  assign out_valid_2a = hold && !hazard;
  assign fire      = out_valid_2a && out_ready_2a;
  assign last_step = (step_q == op_q.steps);
  assign last_fire = fire && last_step;
  assign hold_free = !hold || last_fire;
  assign accept    = in_valid_1a && in_ready_1a;
  assign sb_inc    = fire && (step_q == 3'd0) && stack_eff;

`ifdef CPU_DECODE_SKID_EN
  logic skid_vld_q, in_rdy_q;
  op_t  skid_q;

  // Ready is registered skid-empty so out_ready_2a never reaches in_ready_1a combinationally.
  assign in_ready_1a = in_rdy_q && !kill_4a;
  assign load        = !kill_4a && hold_free && (skid_vld_q || accept);
  assign load_op     = skid_vld_q ? skid_q : in_op;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      in_rdy_q   <= 1'b0;
    end else if (kill_4a) begin
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
    end else if (accept && (skid_vld_q || !hold_free)) begin
      skid_vld_q <= 1'b1;
      skid_q     <= in_op;
      in_rdy_q   <= 1'b0;
    end else if (skid_vld_q && hold_free) begin
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
    end else begin
      in_rdy_q   <= !skid_vld_q;
    end
  end
`else
  // Gated by rst_b so every output reads 0 while reset is held.
  assign in_ready_1a = rst_b && !kill_4a && hold_free;
  assign load        = accept;
  assign load_op     = in_op;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= EMPTY;
      op_q    <= '0;
      step_q  <= 3'd0;
    end else if (kill_4a) begin
      state_q <= EMPTY;
      step_q  <= 3'd0;
    end else if (load) begin
      state_q <= HOLD;
      op_q    <= load_op;
      step_q  <= 3'd0;
    end else if (last_fire) begin
      state_q <= EMPTY;
      step_q  <= 3'd0;
    end else if (fire) begin
      step_q  <= step_q + 3'd1;
    end
  end

  // Issue and retire in the same cycle cancel, even at zero.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else if (sb_inc && !st_retire_5a) begin
      pend_q <= pend_q + PW'(1);
    end else if (!sb_inc && st_retire_5a) begin
      if (pend_q == '0) err_q  <= 1'b1;
      else              pend_q <= pend_q - PW'(1);
    end
  end

  assign imm = SPW'(op_q.instr[10:0]);

  always_comb begin
    top_n_offset_2a = '0;
    case (op_q.topn)
      TOPN_NONE:   top_n_offset_2a = '0;
      TOPN_CONST:  top_n_offset_2a = SPW'(1);
      TOPN_IMM:    top_n_offset_2a = imm;
      TOPN_IMMREG: top_n_offset_2a = st_saved_sp_3a - imm;
      default:     top_n_offset_2a = '0;
    endcase
  end

  assign instruction_2a = op_q.instr;
  assign pc_2a          = op_q.pc;
  assign opcode_2a      = op_q.instr[IW-1:IW-8];
  assign step_2a        = step_q;
  assign last_2a        = hold && last_step;
  assign js_mode_2a     = op_q.pc[0];
  assign pending_2a     = pend_q;
  assign stall_2a       = hold && (hazard || !out_ready_2a);
  assign err_underflow  = err_q;

endmodule

// File: tb/tb_cpu_decode_issue.sv
// Directed bench for cpu_decode_issue (default build, no skid); expected values hand-computed.
module tb_cpu_decode_issue;
  logic        clk = 1'b0;
  logic        rst_b;
  logic        in_valid_1a, in_ready_1a;
  logic [47:0] instruction_1a;
  logic [31:0] pc_1a;
  logic [2:0]  steps_1a;
  logic [1:0]  pops_1a;
  logic [2:0]  pushes_1a;
  logic [1:0]  topn_src_1a;
  logic        kill_4a, st_retire_5a;
  logic [10:0] st_saved_sp_3a;
  logic        out_valid_2a, out_ready_2a;
  logic [47:0] instruction_2a;
  logic [31:0] pc_2a;
  logic [7:0]  opcode_2a;
  logic [2:0]  step_2a;
  logic        last_2a, js_mode_2a;
  logic [10:0] top_n_offset_2a;
  logic [2:0]  pending_2a;
  logic        stall_2a, err_underflow;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cpu_decode_issue dut (
    .clk(clk), .rst_b(rst_b),
    .in_valid_1a(in_valid_1a), .in_ready_1a(in_ready_1a),
    .instruction_1a(instruction_1a), .pc_1a(pc_1a), .steps_1a(steps_1a),
    .pops_1a(pops_1a), .pushes_1a(pushes_1a), .topn_src_1a(topn_src_1a),
    .kill_4a(kill_4a), .st_retire_5a(st_retire_5a), .st_saved_sp_3a(st_saved_sp_3a),
    .out_valid_2a(out_valid_2a), .out_ready_2a(out_ready_2a),
    .instruction_2a(instruction_2a), .pc_2a(pc_2a), .opcode_2a(opcode_2a),
    .step_2a(step_2a), .last_2a(last_2a), .js_mode_2a(js_mode_2a),
    .top_n_offset_2a(top_n_offset_2a), .pending_2a(pending_2a),
    .stall_2a(stall_2a), .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [47:0] mk(input logic [7:0] op, input logic [10:0] imm);
    logic [47:0] w;
    w = '0;
    w[47:40] = op;
    w[10:0] = imm;
    return w;
  endfunction

  task automatic drv(input logic [47:0] ins, input logic [31:0] pc, input logic [2:0] steps,
                     input logic [1:0] pops, input logic [2:0] pushes, input logic [1:0] topn);
    in_valid_1a = 1'b1; instruction_1a = ins; pc_1a = pc; steps_1a = steps;
    pops_1a = pops; pushes_1a = pushes; topn_src_1a = topn;
  endtask

  task automatic idle();
    in_valid_1a = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [47:0] ia, ib, id, ig;

  initial begin
    rst_b = 1'b0; in_valid_1a = 1'b0; instruction_1a = '0; pc_1a = '0; steps_1a = '0;
    pops_1a = '0; pushes_1a = '0; topn_src_1a = '0; kill_4a = 1'b0; st_retire_5a = 1'b0;
    st_saved_sp_3a = 11'd5; out_ready_2a = 1'b0;
    ia = mk(8'h11, 11'd0); ib = mk(8'h22, 11'd0); id = mk(8'hA5, 11'd7); ig = mk(8'h77, 11'd0);
    smp();
    chk("rst_out_valid", out_valid_2a, 0);
    chk("rst_in_ready", in_ready_1a, 0);
    chk("rst_pending", pending_2a, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_last", last_2a, 0);
    chk("rst_stall", stall_2a, 0);
    chk("rst_instr", instruction_2a, 0);
    chk("rst_topn", top_n_offset_2a, 0);
    cyc();

    // back-to-back single-step pushes
    rst_b = 1'b1; out_ready_2a = 1'b1;
    drv(ia, 32'h100, 3'd0, 2'd0, 3'd1, 2'd0);
    smp(); chk("b2b_ready_empty", in_ready_1a, 1); cyc();
    drv(ib, 32'h104, 3'd0, 2'd0, 3'd1, 2'd0);
    smp();
    chk("b2b_valid_a", out_valid_2a, 1); chk("b2b_instr_a", instruction_2a, ia);
    chk("b2b_pend0", pending_2a, 0); chk("b2b_ready_lastfire", in_ready_1a, 1);
    cyc();
    idle();
    smp();
    chk("b2b_valid_b", out_valid_2a, 1); chk("b2b_instr_b", instruction_2a, ib);
    chk("b2b_pend1", pending_2a, 1);
    cyc();

    // hazard on pops with pending op
    st_retire_5a = 1'b1;
    smp(); chk("b2b_empty", out_valid_2a, 0); chk("b2b_pend2", pending_2a, 2); cyc();
    st_retire_5a = 1'b0;
    drv(mk(8'h33, 11'd0), 32'h108, 3'd0, 2'd1, 3'd0, 2'd0);
    smp(); chk("haz_ready", in_ready_1a, 1); chk("haz_pend_pre", pending_2a, 1); cyc();
    idle();
    smp(); chk("haz_stall", stall_2a, 1); chk("haz_valid", out_valid_2a, 0); cyc();
    st_retire_5a = 1'b1;
    smp(); chk("haz_stall_retire_cyc", stall_2a, 1); cyc();
    st_retire_5a = 1'b0;
    smp();
    chk("haz_issue", out_valid_2a, 1); chk("haz_issue_stall", stall_2a, 0);
    chk("haz_issue_pend", pending_2a, 0);
    cyc();

    // IMMREG offset: 5 - 7 mod 2^11
    st_retire_5a = 1'b1;
    drv(id, 32'h1001, 3'd0, 2'd0, 3'd0, 2'd3);
    smp(); chk("haz_pend_back", pending_2a, 1); chk("haz_done_empty", out_valid_2a, 0); cyc();
    st_retire_5a = 1'b0;
    idle();
    smp();
    chk("immreg_offset", top_n_offset_2a, 11'h7FE); chk("immreg_valid", out_valid_2a, 1);
    chk("immreg_opcode", opcode_2a, 8'hA5); chk("immreg_js", js_mode_2a, 1);
    chk("immreg_pc", pc_2a, 32'h1001); chk("immreg_pend", pending_2a, 0);
    cyc();

    // 3-step op with out_ready 1,0,1,1
    drv(mk(8'h5A, 11'h123), 32'h200, 3'd2, 2'd0, 3'd0, 2'd2);
    smp(); cyc();
    idle();
    smp();
    chk("ms_step0", step_2a, 0); chk("ms_valid0", out_valid_2a, 1);
    chk("ms_last0", last_2a, 0); chk("ms_imm", top_n_offset_2a, 11'h123);
    cyc();
    out_ready_2a = 1'b0;
    smp(); chk("ms_step1", step_2a, 1); chk("ms_stall1", stall_2a, 1); chk("ms_valid1", out_valid_2a, 1); cyc();
    out_ready_2a = 1'b1;
    smp(); chk("ms_step1_held", step_2a, 1); chk("ms_stall1_clr", stall_2a, 0); cyc();
    smp(); chk("ms_step2", step_2a, 2); chk("ms_last2", last_2a, 1); chk("ms_ready_last", in_ready_1a, 1); cyc();

    // reset during step 1 of a 3-step stack op
    drv(mk(8'h66, 11'd0), 32'h300, 3'd2, 2'd0, 3'd1, 2'd0);
    smp(); chk("ms_empty_valid", out_valid_2a, 0); chk("ms_empty_last", last_2a, 0); cyc();
    idle();
    smp(); chk("rm_step0", step_2a, 0); cyc();
    smp(); chk("rm_step1", step_2a, 1); chk("rm_pend", pending_2a, 1); cyc();
    rst_b = 1'b0;
    smp();
    chk("rm_valid", out_valid_2a, 0); chk("rm_step", step_2a, 0); chk("rm_pend0", pending_2a, 0);
    chk("rm_instr", instruction_2a, 0); chk("rm_ready", in_ready_1a, 0); chk("rm_last", last_2a, 0);
    cyc();
    rst_b = 1'b1;
    drv(ig, 32'h400, 3'd0, 2'd0, 3'd0, 2'd0);
    smp(); chk("rm_ready_after", in_ready_1a, 1); cyc();
    idle();
    smp();
    chk("rm_new_valid", out_valid_2a, 1); chk("rm_new_step", step_2a, 0);
    chk("rm_new_instr", instruction_2a, ig); chk("rm_new_last", last_2a, 1);
    cyc();

    // kill during step 1 with fetch valid, then underflow
    drv(mk(8'h88, 11'd0), 32'h500, 3'd2, 2'd0, 3'd1, 2'd0);
    smp(); cyc();
    idle();
    smp(); chk("kill_pre_step0", step_2a, 0); cyc();
    kill_4a = 1'b1;
    drv(mk(8'h99, 11'd0), 32'h504, 3'd0, 2'd0, 3'd0, 2'd0);
    smp(); chk("kill_ready", in_ready_1a, 0); chk("kill_step1", step_2a, 1); chk("kill_pend", pending_2a, 1); cyc();
    kill_4a = 1'b0; idle(); st_retire_5a = 1'b1;
    smp(); chk("kill_valid", out_valid_2a, 0); chk("kill_step", step_2a, 0); chk("kill_pend_kept", pending_2a, 1); cyc();
    smp(); chk("uf_pend0", pending_2a, 0); chk("uf_err_pre", err_underflow, 0); cyc();
    st_retire_5a = 1'b0;
    smp(); chk("uf_err", err_underflow, 1); chk("uf_pend_stay", pending_2a, 0); cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
